eoc_frame_arbiter: RTL and testbench
====================================

EOC_FRAME_ARBITER -- requirements
Module: eoc_frame_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, meaning number of aligned-data channels arbitrated (2..8).
REQ-002 Parameter CH_W, default $clog2(NUM_CH), meaning width of the channel index.
REQ-003 Clk  input  1  single clock; all logic on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 ChEmpty  input  NUM_CH  per-channel empty flag of the aligned word source.
REQ-006 ChData  input  NUM_CH*256  per-channel 256-bit aligned word, stable while ChEmpty low.
REQ-007 ChByteEnable  input  NUM_CH*8  per-channel 32-bit-word enables, one bit per 32-bit word.
REQ-008 ChEof  input  NUM_CH  per-channel end-of-frame flag for the presented word.
REQ-009 ChRead  output  NUM_CH  pop strobe to the channel, at most one bit high.
REQ-010 OutEmpty  output  1  high when the output register holds no word.
REQ-011 OutData / OutByteEnable / OutEof  output  256/8/1  registered word, enables and EOF of the held word.
REQ-012 OutChannel  output  CH_W  index of the channel that sourced the held word.
REQ-013 OutRead  input  1  consumer pop, honoured only when OutEmpty low.
REQ-014 Busy  output  1  high while in LOCKED state.

Function
REQ-015 The output stage shall be one register entry with a full flag; OutEmpty = !full.
REQ-016 A transfer occurs in any cycle where a channel is selected and the entry is empty or popped by OutRead in the same cycle; full throughput is 1 word/cycle.
REQ-017 On a transfer, ChRead[sel] shall be high combinationally in that cycle, and ChData/ChByteEnable/ChEof[sel] and sel shall be captured into the output register at the next edge.
REQ-018 ChRead shall never be high for a channel whose ChEmpty is high, nor while the entry is full and OutRead is low.
REQ-019 The FSM shall have states IDLE and LOCKED.
REQ-020 In IDLE, sel shall be the first channel with ChEmpty low, searching from rr_ptr upward with wrap from NUM_CH-1 to 0.
REQ-021 In IDLE, a transfer with ChEof high shall stay in IDLE with rr_ptr <= sel+1 (mod NUM_CH), and a transfer with ChEof low shall go to LOCKED with lock_ch <= sel.
REQ-022 In LOCKED, only lock_ch is eligible; other non-empty channels shall wait even if lock_ch is empty.
REQ-023 In LOCKED, a transfer with ChEof high shall return to IDLE with rr_ptr <= lock_ch+1 (mod NUM_CH).
REQ-024 If no channel is eligible, or the output is stalled, no ChRead is issued and the state and rr_ptr shall hold.
REQ-025 Simultaneous OutRead and transfer shall leave the entry full with the new word; OutRead alone shall empty it.

Reset
REQ-026 Reset shall force IDLE, rr_ptr=0, lock_ch=0, entry empty (OutEmpty=1), OutData=0, OutByteEnable=0, OutEof=0, OutChannel=0, Busy=0, and ChRead=0.
REQ-027 Reset asserted mid-frame shall abandon the lock, and the first word after reset shall be arbitrated from IDLE starting at channel 0.

Configuration
REQ-028 With EOC_ARB_FRAME_LOCK_EN defined, frame lock shall operate per REQ-021..023.
REQ-029 Without EOC_ARB_FRAME_LOCK_EN, LOCKED shall never be entered, Busy shall be tied 0, and every transfer shall set rr_ptr <= sel+1 regardless of ChEof (word-level round robin).

Verification
REQ-030 Reset, then ch0 presents 1 word with EOF=1 and BE=8'h0F -> ChRead=4'b0001 in that cycle; next cycle OutEmpty=0, OutChannel=0, OutByteEnable=8'h0F, OutEof=1.
REQ-031 Lock enabled, ch0 and ch2 both present 3-word frames, OutRead held high -> output order is ch0 x3 then ch2 x3, Busy=1 during the ch0 words 1-2, and no interleaving.
REQ-032 Lock disabled, same stimulus as REQ-031 -> output order alternates ch0, ch2, ch0, ch2, ch0, ch2.
REQ-033 Lock enabled, ch1 is mid-frame and goes empty for 5 cycles while ch3 is non-empty -> no ChRead[3] during the gap; ch1 resumes and finishes, then ch3 is granted.
REQ-034 Output full with OutRead=0 for 4 cycles while ch2 is non-empty -> ChRead=0 throughout; on OutRead=1, ChRead[2] pulses in the same cycle and the new word appears the next cycle.
REQ-035 Reset pulsed while LOCKED on ch3 -> Busy=0 and OutEmpty=1 next cycle; with ch0 and ch3 both pending, ch0 is granted first.

Source files
------------

// File: rtl/eoc_frame_arbiter.sv
// Frame-aware round-robin arbiter feeding aligned 256-bit words from NUM_CH channels into a single output register entry.
// Define EOC_ARB_FRAME_LOCK_EN to keep a channel granted until its EOF word; the default build arbitrates per word.
module eoc_frame_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NUM_CH-1:0]     ChEmpty,
    input  logic [NUM_CH*256-1:0] ChData,
    input  logic [NUM_CH*8-1:0]   ChByteEnable,
    input  logic [NUM_CH-1:0]     ChEof,
    output logic [NUM_CH-1:0]     ChRead,
    output logic                  OutEmpty,
    output logic [255:0]          OutData,
    output logic [7:0]            OutByteEnable,
    output logic                  OutEof,
    output logic [CH_W-1:0]       OutChannel,
    input  logic                  OutRead,
    output logic                  Busy
);

    typedef enum logic [0:0] {IDLE, LOCKED} state_t;

    state_t          state, state_next;
    logic [CH_W-1:0] rr_ptr, rr_ptr_next;
    logic [CH_W-1:0] lock_ch, lock_ch_next;
    logic [CH_W-1:0] sel;
    logic            sel_vld;
    logic            xfer;
    logic            full;

    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
        return CH_W'((int'(base) + off) % NUM_CH);
    endfunction

    // Candidate selection: the locked channel only, or the first non-empty channel from rr_ptr.
    // Scanning downward and overriding leaves the lowest offset from rr_ptr as the winner.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        if (state == LOCKED) begin
            sel     = lock_ch;
            sel_vld = !ChEmpty[lock_ch];
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (!ChEmpty[wrap_add(rr_ptr, i)]) begin
                    sel     = wrap_add(rr_ptr, i);
                    sel_vld = 1'b1;
                end
            end
        end
    end

    assign xfer   = sel_vld && (!full || OutRead) && !Reset;
    assign ChRead = xfer ? (NUM_CH'(1) << sel) : '0;

    always_comb begin
        state_next   = state;
        rr_ptr_next  = rr_ptr;
        lock_ch_next = lock_ch;
        if (xfer) begin
`ifdef EOC_ARB_FRAME_LOCK_EN
            if (ChEof[sel]) begin
                state_next  = IDLE;
                rr_ptr_next = wrap_add(sel, 1);
            end else begin
                state_next   = LOCKED;
                lock_ch_next = sel;
            end
`else
            rr_ptr_next = wrap_add(sel, 1);
`endif
        end
    end

    // Output entry: a new word replaces the held one even when it is popped in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            lock_ch       <= '0;
            full          <= 1'b0;
            OutData       <= '0;
            OutByteEnable <= '0;
            OutEof        <= 1'b0;
            OutChannel    <= '0;
        end else begin
            state   <= state_next;
            rr_ptr  <= rr_ptr_next;
            lock_ch <= lock_ch_next;
            if (xfer) begin
                full          <= 1'b1;
                OutData       <= ChData[256*sel +: 256];
                OutByteEnable <= ChByteEnable[8*sel +: 8];
                OutEof        <= ChEof[sel];
                OutChannel    <= sel;
            end else if (OutRead) begin
                full <= 1'b0;
            end
        end
    end

    assign OutEmpty = !full;

`ifdef EOC_ARB_FRAME_LOCK_EN
    assign Busy = (state == LOCKED);
`else
    assign Busy = 1'b0;
`endif

endmodule

// File: tb/tb_eoc_frame_arbiter.sv
// Randomized and directed bench for eoc_frame_arbiter, checked every cycle against a queue-based reference model.
// Follows EOC_ARB_FRAME_LOCK_EN the same way the design does.
module tb_eoc_frame_arbiter;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
`ifdef EOC_ARB_FRAME_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct packed {
        logic [255:0] d;
        logic [7:0]   be;
        logic         eof;
    } word_t;

    logic                  Clk = 1'b0;
    logic                  Reset;
    logic [NUM_CH-1:0]     ChEmpty;
    logic [NUM_CH*256-1:0] ChData;
    logic [NUM_CH*8-1:0]   ChByteEnable;
    logic [NUM_CH-1:0]     ChEof;
    logic [NUM_CH-1:0]     ChRead;
    logic                  OutEmpty;
    logic [255:0]          OutData;
    logic [7:0]            OutByteEnable;
    logic                  OutEof;
    logic [CH_W-1:0]       OutChannel;
    logic                  OutRead;
    logic                  Busy;

    eoc_frame_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .Clk(Clk), .Reset(Reset), .ChEmpty(ChEmpty), .ChData(ChData),
        .ChByteEnable(ChByteEnable), .ChEof(ChEof), .ChRead(ChRead),
        .OutEmpty(OutEmpty), .OutData(OutData), .OutByteEnable(OutByteEnable),
        .OutEof(OutEof), .OutChannel(OutChannel), .OutRead(OutRead), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    word_t             srcq[NUM_CH][$];
    logic [NUM_CH-1:0] gap;
    int                glog[$];

    // Reference model: frame owner (-1 = none), next search start, and the held word.
    int    m_owner;
    int    m_rr;
    bit    m_full;
    word_t m_word;
    int    m_ch;
    bit    chk_en = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic word_t mk(input logic [7:0] be, input logic eof);
        word_t w;
        for (int k = 0; k < 8; k++) w.d[k*32 +: 32] = $urandom();
        w.be  = be;
        w.eof = eof;
        return w;
    endfunction

    task automatic push_frame(input int c, input int len);
        for (int i = 0; i < len; i++) srcq[c].push_back(mk(8'($urandom()), i == len - 1));
    endtask

    task automatic drive_src();
        for (int c = 0; c < NUM_CH; c++) begin
            if (srcq[c].size() > 0) begin
                ChData[c*256 +: 256]    = srcq[c][0].d;
                ChByteEnable[c*8 +: 8]  = srcq[c][0].be;
                ChEof[c]                = srcq[c][0].eof;
                ChEmpty[c]              = gap[c];
            end else begin
                ChData[c*256 +: 256]    = '0;
                ChByteEnable[c*8 +: 8]  = '0;
                ChEof[c]                = 1'b0;
                ChEmpty[c]              = 1'b1;
            end
        end
    endtask

    // One clock: compare at the falling edge, advance the model, then pop sources after the rising edge.
    task automatic cycle();
        int                cand;
        bit                xfer;
        logic [NUM_CH-1:0] exp_rd;
        @(negedge Clk);
        cand = -1;
        if (!Reset) begin
            if (m_owner >= 0) begin
                if (!ChEmpty[m_owner]) cand = m_owner;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    int c;
                    c = (m_rr + i) % NUM_CH;
                    if (cand < 0 && !ChEmpty[c]) cand = c;
                end
            end
        end
        xfer   = (cand >= 0) && (!m_full || OutRead);
        exp_rd = xfer ? (NUM_CH'(1) << cand) : '0;
        if (chk_en) begin
            chk("chread", ChRead, exp_rd);
            chk("outempty", OutEmpty, !m_full);
            chk("busy", Busy, m_owner >= 0);
            if (m_full) begin
                chk("outdata", OutData, m_word.d);
                chk("outbe", OutByteEnable, m_word.be);
                chk("outeof", OutEof, m_word.eof);
                chk("outch", OutChannel, m_ch);
            end
        end
        if (Reset) begin
            m_owner = -1;
            m_rr    = 0;
            m_full  = 1'b0;
            chk_en  = 1'b1;
        end else if (xfer) begin
            m_word = srcq[cand][0];
            m_ch   = cand;
            m_full = 1'b1;
            glog.push_back(cand);
            if (LOCK && !m_word.eof) begin
                m_owner = cand;
            end else begin
                m_owner = -1;
                m_rr    = (cand + 1) % NUM_CH;
            end
        end else if (OutRead) begin
            m_full = 1'b0;
        end
        @(posedge Clk);
        #1;
        if (xfer) void'(srcq[cand].pop_front());
        drive_src();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive_src();
        cycle();
        Reset = 1'b0;
        drive_src();
        glog.delete();
    endtask

    task automatic drain();
        int n;
        bit pending;
        OutRead = 1'b1;
        gap     = '0;
        drive_src();
        n = 0;
        pending = 1'b1;
        while (pending && n < 300) begin
            pending = m_full;
            for (int c = 0; c < NUM_CH; c++) if (srcq[c].size() > 0) pending = 1'b1;
            if (pending) begin
                cycle();
                n++;
            end
        end
        if (pending) begin
            total++;
            bad++;
            $display("FAIL drain timeout got=%0d want<300", n);
        end
    endtask

    task automatic chk_log(input string nm, input int exp[$]);
        chk({nm, "_len"}, glog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < glog.size(); i++) chk(nm, glog[i], exp[i]);
    endtask

    initial begin
        word_t wa, wb;
        int    e[$];
        m_owner = -1;
        m_rr    = 0;
        m_full  = 1'b0;
        m_word  = '0;
        m_ch    = 0;
        gap     = '0;
        OutRead = 1'b0;
        Reset   = 1'b1;
        drive_src();
        repeat (2) cycle();

        // Reset state
        chk("rst_outempty", OutEmpty, 1);
        chk("rst_busy", Busy, 0);
        chk("rst_chread", ChRead, 0);
        chk("rst_outdata", OutData, 0);
        chk("rst_outbe", OutByteEnable, 0);
        chk("rst_outeof", OutEof, 0);
        chk("rst_outch", OutChannel, 0);
        Reset = 1'b0;

        // Single EOF word on ch0
        srcq[0].push_back(mk(8'h0F, 1'b1));
        drive_src();
        #1 chk("w1_chread", ChRead, 4'b0001);
        cycle();
        chk("w1_outempty", OutEmpty, 0);
        chk("w1_outch", OutChannel, 0);
        chk("w1_outbe", OutByteEnable, 8'h0F);
        chk("w1_outeof", OutEof, 1);
        drain();

        // Two competing 3-word frames
        do_reset();
        OutRead = 1'b1;
        push_frame(0, 3);
        push_frame(2, 3);
        drive_src();
        cycle();
        chk("fr_busy", Busy, LOCK);
        drain();
        if (LOCK) e = '{0, 0, 0, 2, 2, 2};
        else      e = '{0, 2, 0, 2, 0, 2};
        chk_log("fr_order", e);

        // Locked channel runs dry mid-frame
        do_reset();
        OutRead = 1'b1;
        push_frame(1, 3);
        push_frame(3, 1);
        drive_src();
        cycle();
        gap[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_src();
            #1 chk("gap_rd3", ChRead[3], !LOCK && k == 0);
            cycle();
        end
        drain();
        if (LOCK) e = '{1, 1, 1, 3};
        else      e = '{1, 3, 1, 1};
        chk_log("gap_order", e);

        // Output stall
        do_reset();
        OutRead = 1'b0;
        wa = mk(8'hA5, 1'b1);
        wb = mk(8'h3C, 1'b1);
        srcq[2].push_back(wa);
        srcq[2].push_back(wb);
        drive_src();
        cycle();
        for (int k = 0; k < 4; k++) begin
            #1 chk("stall_chread", ChRead, 0);
            cycle();
        end
        chk("stall_hold", OutData, wa.d);
        OutRead = 1'b1;
        drive_src();
        #1 chk("stall_release", ChRead, 4'b0100);
        cycle();
        chk("stall_new", OutData, wb.d);
        chk("stall_full", OutEmpty, 0);
        drain();

        // Reset while a frame is in progress
        do_reset();
        OutRead = 1'b1;
        push_frame(3, 3);
        drive_src();
        cycle();
        push_frame(0, 1);
        push_frame(0, 1);
        drive_src();
        cycle();
        Reset = 1'b1;
        drive_src();
        cycle();
        chk("mrst_busy", Busy, 0);
        chk("mrst_outempty", OutEmpty, 1);
        Reset = 1'b0;
        drive_src();
        #1 chk("mrst_first", ChRead, 4'b0001);
        drain();

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (srcq[c].size() < 4 && $urandom_range(3) == 0) push_frame(c, $urandom_range(1, 4));
                gap[c] = ($urandom_range(3) == 0);
            end
            OutRead = ($urandom_range(9) < 7);
            Reset   = ($urandom_range(299) == 0);
            drive_src();
            cycle();
        end
        Reset = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
